// File: rtl/if_id_stage_if.sv
// IF/ID stage bus: fetch-side inputs, ID/EX hazard inputs and the registered
// IF/ID outputs with stall/flush statistics.
//   pcPlus4, instruction      : fetched PC+4 and instruction word
//   idexMemRead, idexRt       : load-in-EX indication and its destination register
//   branchTaken, jump         : control-transfer resolved in ID this cycle
//   pcPlus4Out, instructionOut, validOut : IF/ID pipeline register contents
//   pcWrite, bubble           : PC load enable / ID/EX control zeroing (combinational)
//   stallCount, flushCount    : saturating event counters
interface if_id_stage_if;
  logic [31:0] pcPlus4;
  logic [31:0] instruction;
  logic        idexMemRead;
  logic [4:0]  idexRt;
  logic        branchTaken;
  logic        jump;
  logic [31:0] pcPlus4Out;
  logic [31:0] instructionOut;
  logic        validOut;
  logic        pcWrite;
  logic        bubble;
  logic [15:0] stallCount;
  logic [15:0] flushCount;

  modport master (
    output pcPlus4, instruction, idexMemRead, idexRt, branchTaken, jump,
    input  pcPlus4Out, instructionOut, validOut, pcWrite, bubble, stallCount, flushCount
  );

  modport slave (
    input  pcPlus4, instruction, idexMemRead, idexRt, branchTaken, jump,
    output pcPlus4Out, instructionOut, validOut, pcWrite, bubble, stallCount, flushCount
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection and branch/jump flush.
//   clock : system clock
//   reset : synchronous active-high reset
//   bus   : if_id_stage_if.slave carrying fetch inputs, hazard inputs and all outputs
// A load in EX whose destination matches rs/rt of the held instruction stalls
// the stage (hold, pcWrite=0, bubble=1). A taken branch or jump without a
// hazard flushes the stage to EMPTY. Stall wins over flush.
module if_id_stage (
  input logic          clock,
  input logic          reset,
  if_id_stage_if.slave bus
);

  typedef enum logic [0:0] {StEmpty, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic       valid;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       hazard;
  logic       flush;

  assign valid = (state_q == StRun);
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];

  // Register 0 is never a real dependency, and an empty slot cannot stall.
  assign hazard = valid && bus.idexMemRead && (bus.idexRt != 5'd0) &&
                  ((bus.idexRt == rs) || (bus.idexRt == rt));
  assign flush  = (bus.branchTaken || bus.jump) && !hazard;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hazard) begin
      if (stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end else if (flush) begin
      state_d = StEmpty;
      pc_d    = bus.pcPlus4;
      instr_d = 32'h0;
      if (flush_cnt_q != 16'hFFFF) begin
        flush_cnt_d = flush_cnt_q + 16'd1;
      end
    end else begin
      state_d = StRun;
      pc_d    = bus.pcPlus4;
      instr_d = bus.instruction;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StEmpty;
      pc_q        <= 32'h0;
      instr_q     <= 32'h0;
      stall_cnt_q <= 16'h0;
      flush_cnt_q <= 16'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pcPlus4Out     = pc_q;
  assign bus.instructionOut = instr_q;
  assign bus.validOut       = valid;
  assign bus.pcWrite        = !hazard;
  assign bus.bubble         = hazard || !valid;
  assign bus.stallCount     = stall_cnt_q;
  assign bus.flushCount     = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed, table-driven bench for if_id_stage. Each vector drives inputs,
// checks the combinational pcWrite/bubble before the edge, then checks the
// registered outputs after the edge.
module tb_if_id_stage;

  logic clock;
  logic reset;

  if_id_stage_if bus ();

  if_id_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mr;
    logic [4:0]  rt;
    logic        br;
    logic        jmp;
    logic        exp_pcw;
    logic        exp_bub;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic [15:0] exp_stall;
    logic [15:0] exp_flush;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic mr,
                       input logic [4:0] rt, input logic br, input logic jmp);
    bus.pcPlus4     = pc;
    bus.instruction = instr;
    bus.idexMemRead = mr;
    bus.idexRt      = rt;
    bus.branchTaken = br;
    bus.jump        = jmp;
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic valid, input logic [15:0] stall, input logic [15:0] flush);
    chk({tag, ".pcPlus4Out"}, bus.pcPlus4Out, pc);
    chk({tag, ".instructionOut"}, bus.instructionOut, instr);
    chk({tag, ".validOut"}, {31'd0, bus.validOut}, {31'd0, valid});
    chk({tag, ".stallCount"}, {16'd0, bus.stallCount}, {16'd0, stall});
    chk({tag, ".flushCount"}, {16'd0, bus.flushCount}, {16'd0, flush});
  endtask

  vec_t vecs[9];

  initial begin
    // pc, instr, mr, rt, br, jmp | pcw, bub (pre-edge) | pc, instr, valid, stall, flush (post-edge)
    // Load from EMPTY.
    vecs[0] = '{32'h4,  32'h8C220004, 1'b0, 5'd0, 1'b0, 1'b0,
                1'b1, 1'b1, 32'h4,  32'h8C220004, 1'b1, 16'd0, 16'd0};
    // Load next, bubble must be 0 with a valid instruction and no hazard.
    vecs[1] = '{32'h8,  32'h00432020, 1'b0, 5'd2, 1'b0, 1'b0,
                1'b1, 1'b0, 32'h8,  32'h00432020, 1'b1, 16'd0, 16'd0};
    // Load-use on rs=2: hold.
    vecs[2] = '{32'hC,  32'hDEADBEEF, 1'b1, 5'd2, 1'b0, 1'b0,
                1'b0, 1'b1, 32'h8,  32'h00432020, 1'b1, 16'd1, 16'd0};
    // Same stall with branchTaken: branch ignored.
    vecs[3] = '{32'hC,  32'hDEADBEEF, 1'b1, 5'd2, 1'b1, 1'b0,
                1'b0, 1'b1, 32'h8,  32'h00432020, 1'b1, 16'd2, 16'd0};
    // Jump, no hazard: flush.
    vecs[4] = '{32'h10, 32'h12345678, 1'b0, 5'd2, 1'b0, 1'b1,
                1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 16'd2, 16'd1};
    // EMPTY: load matching idexRt cannot stall.
    vecs[5] = '{32'h14, 32'h00A62820, 1'b1, 5'd0, 1'b0, 1'b0,
                1'b1, 1'b1, 32'h14, 32'h00A62820, 1'b1, 16'd2, 16'd1};
    // idexRt=0 never a hazard; branch flushes.
    vecs[6] = '{32'h18, 32'h8C220004, 1'b1, 5'd0, 1'b1, 1'b0,
                1'b1, 1'b0, 32'h18, 32'h0,        1'b0, 16'd2, 16'd2};
    // Branch while EMPTY still flushes.
    vecs[7] = '{32'h1C, 32'h11111111, 1'b0, 5'd0, 1'b1, 1'b0,
                1'b1, 1'b1, 32'h1C, 32'h0,        1'b0, 16'd2, 16'd3};
    // Back to RUN.
    vecs[8] = '{32'h20, 32'h00432020, 1'b0, 5'd0, 1'b0, 1'b0,
                1'b1, 1'b1, 32'h20, 32'h00432020, 1'b1, 16'd2, 16'd3};

    drive(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_regs("reset", 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
    chk("reset.pcWrite", {31'd0, bus.pcWrite}, 32'd1);
    chk("reset.bubble", {31'd0, bus.bubble}, 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].pc, vecs[i].instr, vecs[i].mr, vecs[i].rt, vecs[i].br, vecs[i].jmp);
      #1;
      chk({tag, ".pcWrite"}, {31'd0, bus.pcWrite}, {31'd0, vecs[i].exp_pcw});
      chk({tag, ".bubble"}, {31'd0, bus.bubble}, {31'd0, vecs[i].exp_bub});
      @(posedge clock);
      #1;
      chk_regs(tag, vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_valid,
               vecs[i].exp_stall, vecs[i].exp_flush);
    end

    // Reset asserted mid-stall clears the held instruction.
    drive(32'h24, 32'hCAFEF00D, 1'b1, 5'd3, 1'b0, 1'b0);
    #1;
    chk("midstall.pcWrite", {31'd0, bus.pcWrite}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_regs("midreset", 32'h0, 32'h0, 1'b0, 16'd0, 16'd0);
    chk("midreset.pcWrite", {31'd0, bus.pcWrite}, 32'd1);
    chk("midreset.bubble", {31'd0, bus.bubble}, 32'd1);
    reset = 1'b0;

    // Saturation: load, then 65535 stalls, then one more.
    drive(32'h4, 32'h00432020, 1'b0, 5'd0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    drive(32'h8, 32'h0, 1'b1, 5'd2, 1'b0, 1'b0);
    repeat (65535) @(posedge clock);
    #1;
    chk("sat.preset", {16'd0, bus.stallCount}, 32'h0000FFFF);
    @(posedge clock);
    #1;
    chk_regs("sat", 32'h4, 32'h00432020, 1'b1, 16'hFFFF, 16'd0);
    chk("sat.pcWrite", {31'd0, bus.pcWrite}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
